// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per cycle, valid/ready on both sides.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               div_by_zero
);

   localparam int DW = 2 * WIDTH;
   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [DW-1:0]    shift_r;
   logic [WIDTH:0]   part_r;
   logic [WIDTH-1:0] dvs_r;
   logic [CW-1:0]    cnt_r;
   logic             zero_r;

   logic [WIDTH+1:0] trial_s;
   logic [WIDTH:0]   next_part_s;
   logic             q_bit_s;
   logic [DW-1:0]    next_shift_s;

   // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
   always_comb begin
      trial_s      = {part_r, shift_r[DW-1]};
      next_part_s  = trial_s[WIDTH:0];
      q_bit_s      = 1'b0;
      if (trial_s >= {2'b00, dvs_r}) begin
         q_bit_s     = 1'b1;
         next_part_s = (WIDTH+1)'(trial_s - {2'b00, dvs_r});
      end else begin
         q_bit_s     = 1'b0;
         next_part_s = trial_s[WIDTH:0];
      end
      next_shift_s = {shift_r[DW-2:0], q_bit_s};
   end

   // Control FSM with registered handshake and result outputs.
   // The dividend register doubles as the quotient accumulator as its bits shift out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         shift_r     <= '0;
         part_r      <= '0;
         dvs_r       <= '0;
         cnt_r       <= '0;
         zero_r      <= 1'b0;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready) begin
                  shift_r  <= dividend;
                  dvs_r    <= divisor;
                  part_r   <= '0;
                  cnt_r    <= CW'(DW);
                  zero_r   <= (divisor == '0);
                  in_ready <= 1'b0;
                  state_r  <= BUSY;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            BUSY: begin
               if (zero_r) begin
                  quotient    <= {DW{1'b1}};
                  remainder   <= shift_r[WIDTH-1:0];
                  div_by_zero <= 1'b1;
                  out_valid   <= 1'b1;
                  cnt_r       <= '0;
                  state_r     <= DONE;
               end else begin
                  shift_r <= next_shift_s;
                  part_r  <= next_part_s;
                  cnt_r   <= cnt_r - CW'(1);
                  if (cnt_r == CW'(1)) begin
                     quotient    <= next_shift_s;
                     remainder   <= next_part_s[WIDTH-1:0];
                     div_by_zero <= 1'b0;
                     out_valid   <= 1'b1;
                     state_r     <= DONE;
                  end else begin
                     state_r <= BUSY;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_r   <= IDLE;
               end else begin
                  state_r   <= DONE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model with a per-cycle
// compare process, plus directed vectors with hand-computed results.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] dividend = 16'd0;
   logic [7:0]  divisor = 8'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;

   int assert_cnt = 0;
   int fail_cnt = 0;
   int cyc = 0;
   bit exp_rdy = 1'b0;

   typedef struct {
      logic [15:0] q;
      logic [7:0]  r;
      logic        dz;
      int          lat;
      int          acc;
   } exp_t;
   exp_t mq[$];

   seq_divider #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      assert_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   function automatic bit model_ov();
      return (mq.size() > 0) && ((cyc - mq[0].acc) >= mq[0].lat);
   endfunction

   // Reference model: a queue of pending results with their expected completion cycles.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
            exp_rdy = 1'b0;
         end else begin
            bit was_rdy;
            bit ov;
            was_rdy = exp_rdy;
            ov = model_ov();
            cyc = cyc + 1;
            if (ov && out_ready) void'(mq.pop_front());
            if (in_valid && was_rdy) begin
               exp_t e;
               if (divisor == 8'd0) begin
                  e.q = 16'hFFFF; e.r = dividend[7:0]; e.dz = 1'b1; e.lat = 1;
               end else begin
                  e.q = dividend / 16'(divisor);
                  e.r = 8'(dividend % 16'(divisor));
                  e.dz = 1'b0; e.lat = 16;
               end
               e.acc = cyc;
               mq.push_back(e);
            end
            exp_rdy = (mq.size() == 0);
         end
      end
   end

   // Compare process: handshake flags every cycle, results whenever a result is expected.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(model_ov()));
            if (out_valid && model_ov()) begin
               chk("model_quotient", 32'(quotient), 32'(mq[0].q));
               chk("model_remainder", 32'(remainder), 32'(mq[0].r));
               chk("model_div_by_zero", 32'(div_by_zero), 32'(mq[0].dz));
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic issue(input logic [15:0] dvd, input logic [7:0] dvs);
      int t;
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         assert_cnt++; fail_cnt++;
         $display("FAIL issue_timeout: in_ready got 0, expected 1 within 200 cycles");
      end
      in_valid = 1'b1;
      dividend = dvd;
      divisor  = dvs;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) begin
         assert_cnt++; fail_cnt++;
         $display("FAIL done_timeout: out_valid got 0, expected 1 within 100 cycles");
      end
   endtask

   task automatic run_dir(input string name, input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [15:0] eq, input logic [7:0] er, input logic edz,
                          input int elat);
      int lat;
      out_ready = 1'b1;
      issue(dvd, dvs);
      wait_done(lat);
      chk({name, "_latency"}, 32'(lat), 32'(elat));
      chk({name, "_quotient"}, 32'(quotient), 32'(eq));
      chk({name, "_remainder"}, 32'(remainder), 32'(er));
      chk({name, "_dbz"}, 32'(div_by_zero), 32'(edz));
      @(negedge clk);
      chk({name, "_ready_after"}, 32'(in_ready), 32'd1);
      chk({name, "_valid_after"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int lat;
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_first_edge", 32'(in_ready), 32'd1);

      run_dir("d15000_7", 16'd15000, 8'd7, 16'd2142, 8'd6, 1'b0, 16);
      run_dir("d65535_255", 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 16);
      run_dir("d65025_255", 16'd65025, 8'd255, 16'd255, 8'd0, 1'b0, 16);
      run_dir("d5_200", 16'd5, 8'd200, 16'd0, 8'd5, 1'b0, 16);
      run_dir("d0_9", 16'd0, 8'd9, 16'd0, 8'd0, 1'b0, 16);
      run_dir("d100_0", 16'd100, 8'd0, 16'hFFFF, 8'h64, 1'b1, 1);
      run_dir("d100_3", 16'd100, 8'd3, 16'd33, 8'd1, 1'b0, 16);

      // Backpressure with garbage operands presented while the result is held.
      out_ready = 1'b0;
      issue(16'd15000, 8'd7);
      wait_done(lat);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2 == 0);
         dividend = 16'($urandom);
         divisor  = 8'($urandom);
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_ready", 32'(in_ready), 32'd0);
         chk("bp_quotient", 32'(quotient), 32'd2142);
         chk("bp_remainder", 32'(remainder), 32'd6);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      chk("bp_release_valid", 32'(out_valid), 32'd0);

      // Asynchronous reset in the 8th BUSY cycle.
      issue(16'd15000, 8'd7);
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_quotient", 32'(quotient), 32'd0);
      chk("mid_rst_remainder", 32'(remainder), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_rdy_first_edge", 32'(in_ready), 32'd1);
      run_dir("d200_10", 16'd200, 8'd10, 16'd20, 8'd0, 1'b0, 16);

      // Random operands with random consumer stalls.
      for (int i = 0; i < 1000; i++) begin
         int a;
         int b;
         logic [15:0] dvd;
         logic [7:0]  dvs;
         bit prod;
         prod = (i % 4 == 0);
         b = $urandom_range(1, 255);
         a = prod ? $urandom_range(0, 255) : $urandom_range(0, 65535);
         dvd = prod ? 16'(a * b) : 16'(a);
         dvs = 8'(b);
         out_ready = 1'b0;
         issue(dvd, dvs);
         wait_done(lat);
         chk("rnd_identity", 32'(quotient) * 32'(dvs) + 32'(remainder), 32'(dvd));
         chk("rnd_rem_lt_div", 32'(remainder < dvs), 32'd1);
         if (prod) chk("rnd_product_factor", 32'(quotient), 32'(a));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
